step_cmd_queue: RTL and testbench

STEP_CMD_QUEUE -- requirements
Module: step_cmd_queue

---
 rtl/step_cmd_queue_pkg.sv | 36 +++
 rtl/step_cmd_queue_if.sv | 26 ++
 rtl/step_cmd_queue_cmd_fifo.sv | 56 +++++
 rtl/step_cmd_queue.sv | 146 ++++++++++++++
 tb/tb_step_cmd_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_cmd_queue_pkg.sv
// rtl/step_cmd_queue_pkg.sv - shared motor types: sequencer states, command layout, driver bridge-state codes
package step_cmd_queue_pkg;

  // Sequencer states; IDLE is the only state in which busy is low.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_DWELL     = 3'd4
  } state_t;

  // H-bridge driver phase codes; all-zero means the driver is idle.
  localparam logic [3:0] HB_IDLE = 4'b0000;
  localparam logic [3:0] HB_S1   = 4'b1010;
  localparam logic [3:0] HB_S2   = 4'b0110;
  localparam logic [3:0] HB_S3   = 4'b0101;
  localparam logic [3:0] HB_S4   = 4'b1001;

  localparam int STEP_W = 32;
  localparam int CMD_W  = STEP_W + 1;

  // Last WAIT_BUSY cycle index before giving up on a driver that never starts (four cycles).
  localparam logic [1:0] WB_LAST = 2'd3;

  // One queued move: step count and direction (1 = forward).
  typedef struct packed {
    logic [STEP_W-1:0] steps;
    logic              dir;
  } cmd_t;

  function automatic logic hb_is_idle(input logic [3:0] hb);
    return hb == HB_IDLE;
  endfunction

endpackage

// File: rtl/step_cmd_queue_if.sv
// rtl/step_cmd_queue_if.sv - command handshake between host and step command queue
interface step_cmd_queue_if;
  import step_cmd_queue_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;

  // Host side offers commands.
  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    input  cmd_ready
  );

  // Queue side accepts commands.
  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    output cmd_ready
  );

endinterface

// File: rtl/step_cmd_queue_cmd_fifo.sv
// rtl/step_cmd_queue_cmd_fifo.sv - synchronous show-ahead FIFO with occupancy count and flush
module cmd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A flush wins over any push or pop in the same cycle; full/empty guard the pointers.
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign full     = (count == DEPTH_U[AW:0]);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/step_cmd_queue.sv
// rtl/step_cmd_queue.sv - queues step/direction moves and feeds them one at a time to an H-bridge driver
module step_cmd_queue
  import step_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DWELL = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  step_cmd_queue_if.slave        cmd,
  input  logic                   abort,
  input  logic [3:0]             hb_state,
  output logic [STEP_W-1:0]      counter_out,
  output logic                   dir_out,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam logic [7:0] DWELL_LAST = (DWELL > 0) ? 8'(DWELL - 1) : 8'd0;

  state_t            state;
  state_t            state_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CMD_W-1:0]  fifo_head;
  cmd_t              head;
  logic              push;
  logic              pop;
  logic              load;
  logic              done_set;
  logic [STEP_W-1:0] steps_q;
  logic              dir_q;
  logic              done_q;
  logic [1:0]        wb_cnt;
  logic [7:0]        dwell_cnt;

  // Ready depends only on occupancy, never on a pop in the same cycle.
  assign cmd.cmd_ready = !rst && !fifo_full;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign head          = cmd_t'(fifo_head);

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data ({cmd.cmd_steps, cmd.cmd_dir}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic, including the pop/load/done decisions that go with each transition.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    done_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !abort && hb_is_idle(hb_state)) begin
          pop = 1'b1;
          if (head.steps != '0) begin
            load       = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      ST_ISSUE: state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!hb_is_idle(hb_state)) begin
          state_next = ST_WAIT_IDLE;
        end else if (wb_cnt == WB_LAST) begin
          state_next = ST_IDLE;
          done_set   = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (hb_is_idle(hb_state)) begin
          done_set   = 1'b1;
          state_next = (DWELL > 0) ? ST_DWELL : ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (dwell_cnt == DWELL_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: the step count is visible only during ISSUE, and an abort there suppresses it.
  always_comb begin
    counter_out = '0;
    if (state == ST_ISSUE && !abort) counter_out = steps_q;
    busy = (state != ST_IDLE);
  end

  assign dir_out = dir_q;
  assign done    = done_q;

  // Latch the popped move; direction keeps its last issued value between moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      steps_q <= '0;
      dir_q   <= 1'b1;
    end else if (load) begin
      steps_q <= head.steps;
      dir_q   <= head.dir;
    end
  end

  // Done is registered so it lands one cycle after the retiring transition; reset drops any pending pulse.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_set;
  end

  // Count quiet WAIT_BUSY cycles so an unresponsive driver does not stall the queue.
  always_ff @(posedge clk) begin
    if (rst)                                                   wb_cnt <= '0;
    else if (state == ST_WAIT_BUSY && state_next == ST_WAIT_BUSY) wb_cnt <= wb_cnt + 1'b1;
    else                                                       wb_cnt <= '0;
  end

  // Count dwell cycles between consecutive moves.
  always_ff @(posedge clk) begin
    if (rst)                                           dwell_cnt <= '0;
    else if (state == ST_DWELL && state_next == ST_DWELL) dwell_cnt <= dwell_cnt + 1'b1;
    else                                               dwell_cnt <= '0;
  end

endmodule

// File: tb/tb_step_cmd_queue.sv
// tb/tb_step_cmd_queue.sv - directed bench with a queue-level reference model for step_cmd_queue
module tb_step_cmd_queue;
  import step_cmd_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int DWELL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic [3:0]  hb_state;
  logic [31:0] counter_out;
  logic        dir_out;
  logic        busy;
  logic        done;
  logic [2:0]  fifo_count;

  step_cmd_queue_if cmd_if();

  step_cmd_queue #(.DEPTH(DEPTH), .DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .abort       (abort),
    .hb_state    (hb_state),
    .counter_out (counter_out),
    .dir_out     (dir_out),
    .busy        (busy),
    .done        (done),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int push_cyc   = 0;
  int n_issue    = 0;
  int n_done     = 0;
  bit drv_en     = 1'b0;
  bit drv_force  = 1'b0;
  int drv_len    = 3;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] s, input logic d);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_steps = s;
    cmd_if.cmd_dir   = d;
    push_cyc         = cyc;
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver model: after seeing a step count it runs for drv_len cycles, or stays busy while forced.
  initial begin : driver
    int  left;
    bit  seen;
    left     = 0;
    seen     = 1'b0;
    hb_state = HB_IDLE;
    forever begin
      @(negedge clk);
      seen = drv_en && (counter_out != 0);
      @(posedge clk);
      #1;
      if (seen) left = drv_len;
      if (drv_force) hb_state = HB_S1;
      else if (left > 0) begin
        case (left % 4)
          0:       hb_state = HB_S1;
          1:       hb_state = HB_S2;
          2:       hb_state = HB_S3;
          default: hb_state = HB_S4;
        endcase
        left--;
      end else hb_state = HB_IDLE;
    end
  end

  // Reference model: a queue of moves plus the progress of the move in flight.
  logic [32:0] mq[$];
  bit          m_act   = 1'b0;
  int          m_age   = 0;
  bit          m_seen  = 1'b0;
  int          m_quiet = 0;
  int          m_dwell = 0;
  logic [31:0] m_steps = '0;
  logic        m_dir   = 1'b1;
  logic        m_done  = 1'b0;

  always @(negedge clk) begin
    logic        e_ready;
    logic [31:0] e_cnt;
    logic        nd;
    logic [32:0] hd;
    if (cyc > 0) begin
      e_ready = !rst && (mq.size() < DEPTH);
      e_cnt   = (m_act && m_age == 0 && !abort) ? m_steps : 32'd0;
      check("counter_out", counter_out, e_cnt);
      check("dir_out", dir_out, m_dir);
      check("busy", busy, (m_act || m_dwell > 0) ? 1 : 0);
      check("done", done, m_done);
      check("fifo_count", fifo_count, mq.size());
      check("cmd_ready", cmd_if.cmd_ready, e_ready);
      if (counter_out != 0) n_issue++;
      if (done) n_done++;
      if (rst) begin
        mq.delete();
        m_act = 1'b0; m_age = 0; m_seen = 1'b0; m_quiet = 0;
        m_dwell = 0; m_dir = 1'b1; m_done = 1'b0;
      end else begin
        nd = 1'b0;
        if (m_act) begin
          if (m_age == 0) begin
            m_age = 1; m_seen = 1'b0; m_quiet = 0;
          end else if (!m_seen) begin
            if (hb_state != HB_IDLE) m_seen = 1'b1;
            else begin
              m_quiet++;
              if (m_quiet == 4) begin m_act = 1'b0; nd = 1'b1; end
            end
          end else if (hb_state == HB_IDLE) begin
            m_act = 1'b0; nd = 1'b1; m_dwell = DWELL;
          end
        end else if (m_dwell > 0) begin
          m_dwell--;
        end else if (mq.size() > 0 && hb_state == HB_IDLE && !abort) begin
          hd = mq.pop_front();
          if (hd[32:1] == 32'd0) nd = 1'b1;
          else begin
            m_act = 1'b1; m_age = 0; m_steps = hd[32:1]; m_dir = hd[0];
          end
        end
        if (abort) mq.delete();
        else if (cmd_if.cmd_valid && e_ready) mq.push_back({cmd_if.cmd_steps, cmd_if.cmd_dir});
        m_done = nd;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, ic, base_i, base_d;
    rst = 1'b1; abort = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_steps = '0; cmd_if.cmd_dir = 1'b0;

    // Reset behaviour.
    @(negedge clk);
    check("ready_during_rst", cmd_if.cmd_ready, 0);
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_counter", counter_out, 0);
    check("rst_dir", dir_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step();

    // Single move: latency, value, done, dwell length.
    drv_en = 1'b1; drv_len = 3;
    base_i = n_issue; base_d = n_done;
    push(32'd3, 1'b1);
    @(negedge clk);
    w = 0;
    while (counter_out == 0 && w < 20) begin @(negedge clk); w++; end
    check("s1_issue_seen", counter_out != 0, 1);
    check("s1_latency", cyc - push_cyc, 2);
    check("s1_counter", counter_out, 3);
    check("s1_dir", dir_out, 1);
    w = 0;
    while (!done && w < 40) begin @(negedge clk); w++; end
    check("s1_done_seen", done, 1);
    n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    check("s1_dwell_busy", n, DWELL);
    step();
    check("s1_issues", n_issue - base_i, 1);
    check("s1_dones", n_done - base_d, 1);

    // Zero-step command is retired without touching the driver.
    base_i = n_issue; base_d = n_done;
    push(32'd0, 1'b0);
    @(negedge clk);
    w = 0;
    while (!done && w < 10) begin @(negedge clk); w++; end
    check("s2_done_latency", cyc - push_cyc, 2);
    check("s2_busy", busy, 0);
    step(); step();
    check("s2_no_issue", n_issue - base_i, 0);
    check("s2_dones", n_done - base_d, 1);
    check("s2_count", fifo_count, 0);
    check("s2_dir_kept", dir_out, 1);

    // Five back-to-back commands against a busy driver: backpressure at DEPTH.
    drv_force = 1'b1;
    step(); step();
    base_d = n_done;
    for (int k = 1; k <= 4; k++) begin
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 32'(k); cmd_if.cmd_dir = k[0];
      step();
    end
    cmd_if.cmd_steps = 32'd5; cmd_if.cmd_dir = 1'b1;
    @(negedge clk);
    check("s3_ready_full", cmd_if.cmd_ready, 0);
    check("s3_count_full", fifo_count, 4);
    step(); step();
    @(negedge clk);
    check("s3_count_held", fifo_count, 4);
    drv_force = 1'b0; drv_len = 2;
    w = 0;
    while (!cmd_if.cmd_ready && w < 20) begin @(negedge clk); w++; end
    check("s3_ready_after_pop", cmd_if.cmd_ready, 1);
    step();
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    w = 0;
    while (!(fifo_count == 0 && !busy) && w < 400) begin @(negedge clk); w++; end
    check("s3_drained", fifo_count == 0 && !busy, 1);
    step();
    check("s3_dones", n_done - base_d, 5);

    // Abort while the driver is running: queue flushed, current move completes.
    drv_len = 10;
    base_i = n_issue; base_d = n_done;
    for (int k = 1; k <= 4; k++) begin
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 32'(10 + k); cmd_if.cmd_dir = 1'b0;
      step();
    end
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    w = 0;
    while (!(fifo_count == 3 && hb_state != HB_IDLE) && w < 30) begin @(negedge clk); w++; end
    check("s4_three_queued", fifo_count, 3);
    step();
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 32'd99;
    step();
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("s4_flushed", fifo_count, 0);
    check("s4_still_busy", busy, 1);
    w = 0;
    while (busy && w < 60) begin @(negedge clk); w++; end
    step();
    check("s4_issues", n_issue - base_i, 1);
    check("s4_dones", n_done - base_d, 1);
    check("s4_idle", busy, 0);
    check("s4_push_dropped", fifo_count, 0);

    // Driver ignores the command: four WAIT_BUSY cycles then retire.
    drv_en = 1'b0;
    push(32'd7, 1'b1);
    @(negedge clk);
    w = 0;
    while (counter_out == 0 && w < 10) begin @(negedge clk); w++; end
    ic = cyc;
    check("s5_counter", counter_out, 7);
    check("s5_dir", dir_out, 1);
    w = 0;
    while (!done && w < 20) begin @(negedge clk); w++; end
    check("s5_timeout_done", cyc - ic, 5);
    check("s5_idle", busy, 0);
    step();

    // Abort in ISSUE suppresses the step count; move then times out.
    drv_en = 1'b1; drv_len = 3;
    base_i = n_issue; base_d = n_done;
    push(32'd9, 1'b0);
    step();
    abort = 1'b1;
    @(negedge clk);
    check("s6_counter_suppressed", counter_out, 0);
    check("s6_busy", busy, 1);
    step();
    abort = 1'b0;
    @(negedge clk);
    w = 0;
    while (busy && w < 20) begin @(negedge clk); w++; end
    step();
    check("s6_issues", n_issue - base_i, 0);
    check("s6_dones", n_done - base_d, 1);

    // Reset mid-move with two queued: everything discarded, no done.
    drv_len = 10;
    for (int k = 0; k < 3; k++) begin
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 32'(20 + k); cmd_if.cmd_dir = 1'b0;
      step();
    end
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    w = 0;
    while (!(fifo_count == 2 && hb_state != HB_IDLE) && w < 30) begin @(negedge clk); w++; end
    check("s7_two_queued", fifo_count, 2);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("s7_ready_in_rst", cmd_if.cmd_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("s7_count", fifo_count, 0);
    check("s7_counter", counter_out, 0);
    check("s7_dir", dir_out, 1);
    check("s7_busy", busy, 0);
    check("s7_done", done, 0);
    check("s7_ready", cmd_if.cmd_ready, 1);
    step();
    base_i = n_issue; base_d = n_done;
    repeat (30) step();
    check("s7_no_issue", n_issue - base_i, 0);
    check("s7_no_done", n_done - base_d, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
